// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_pkg
// Description : Shared defaults, pointer-width helper and operation encoding
//               for the stack_2bit LIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

    // Default word width and number of entries
    localparam int c_DEF_WIDTH = 2;
    localparam int c_DEF_DEPTH = 8;

    // Count/pointer width: one extra bit so that "full" (count == DEPTH)
    // is representable alongside the address bits.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int c_DEF_PTR_W = ptr_width(c_DEF_DEPTH);

    // Effective operation for one clock, after full/empty qualification
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_SWAP = 2'd3
    } stack_op_e;

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
// Module      : stack_mem
// Description : Storage array for the LIFO. Synchronous write, asynchronous
//               read. Contents are not reset; unread entries are don't-care.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_mem #(
    parameter int WIDTH  = 2,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write one entry on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read is combinational so a pop and an overwrite on the same edge
    // both see the old top-of-stack value.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule : stack_mem
`default_nettype wire

// File: rtl/stack_2bit.sv
`default_nettype none
// ============================================================================
// Module      : stack_2bit
// Description : DEPTH-entry LIFO with registered pop data, combinational
//               empty/full flags and simultaneous push/pop (top replace).
// Revision    : 1.0 - initial release
// ============================================================================
module stack_2bit
    import stack_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int DEPTH = c_DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int c_PTR_W  = ptr_width(DEPTH);
    localparam int c_ADDR_W = c_PTR_W - 1;

    logic [c_PTR_W-1:0]  r_count;
    logic [WIDTH-1:0]    r_data_out;

    stack_op_e           w_op;
    logic                w_empty;
    logic                w_full;
    logic                w_wr_en;
    logic [c_ADDR_W-1:0] w_top_addr;
    logic [c_ADDR_W-1:0] w_wr_addr;
    logic [WIDTH-1:0]    w_rd_data;

    // Flags are pure decodes of the count so they track it the same cycle
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_PTR_W'(DEPTH));

    // Index of the current top entry. When the stack is full the address
    // bits of the count are zero and the subtraction wraps to DEPTH-1.
    assign w_top_addr = r_count[c_ADDR_W-1:0] - c_ADDR_W'(1);

    // Qualify the raw requests into the single operation performed this edge
    always_comb begin
        w_op = OP_IDLE;
        unique case ({push, pop})
            2'b10:   w_op = w_full  ? OP_IDLE : OP_PUSH;
            2'b01:   w_op = w_empty ? OP_IDLE : OP_POP;
            2'b11:   w_op = w_empty ? OP_PUSH : OP_SWAP;
            default: w_op = OP_IDLE;
        endcase
    end

    // A push writes the next free slot; a swap overwrites the current top.
    // Writes are blocked while reset is asserted so reset overrides a push.
    assign w_wr_en   = rst && ((w_op == OP_PUSH) || (w_op == OP_SWAP));
    assign w_wr_addr = (w_op == OP_SWAP) ? w_top_addr : r_count[c_ADDR_W-1:0];

    stack_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (data_in),
        .i_rd_addr (w_top_addr),
        .o_rd_data (w_rd_data)
    );

    // Count and pop-data registers; data_out only moves on a real pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            unique case (w_op)
                OP_PUSH: begin
                    r_count <= r_count + c_PTR_W'(1);
                end
                OP_POP: begin
                    r_count    <= r_count - c_PTR_W'(1);
                    r_data_out <= w_rd_data;
                end
                OP_SWAP: begin
                    r_data_out <= w_rd_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign empty    = w_empty;
    assign full     = w_full;

endmodule : stack_2bit
`default_nettype wire

// File: tb/tb_stack_2bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_2bit
// Description : Directed, table-driven self-checking bench for stack_2bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_2bit;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic [1:0] data_in;
    logic [1:0] data_out;
    logic       empty;
    logic       full;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic [1:0] din;
        logic [1:0] exp_dout;
        logic       exp_empty;
        logic       exp_full;
    } vec_t;

    vec_t vecs[$];

    stack_2bit #(
        .WIDTH (2),
        .DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic p, input logic q, input logic [1:0] d,
                       input logic [1:0] od, input logic oe, input logic of_);
        vec_t v;
        v.push = p; v.pop = q; v.din = d;
        v.exp_dout = od; v.exp_empty = oe; v.exp_full = of_;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic p, input logic q, input logic [1:0] d);
        @(negedge clk);
        push = p; pop = q; data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; data_in = 2'd0;
        rst  = 1'b0;

        // ---------------- reset state ----------------
        #12;
        chk("rst_empty", {7'd0, empty}, 8'd1);
        chk("rst_full",  {7'd0, full},  8'd0);
        chk("rst_dout",  {6'd0, data_out}, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- vector table ----------------
        // pop on empty after reset: ignored
        add(0, 1, 2'd0, 2'd0, 1, 0);
        // fill 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++)
            add(1, 0, 2'(i % 4), 2'd0, 0, (i == 7));
        // overflow pushes of 2'b10
        add(1, 0, 2'd2, 2'd0, 0, 1);
        add(1, 0, 2'd2, 2'd0, 0, 1);
        // drain 10 pops: 3,2,1,0,3,2,1,0 then hold
        begin
            logic [1:0] exp_seq [8];
            exp_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
            for (int i = 0; i < 8; i++)
                add(0, 1, 2'd0, exp_seq[i], (i == 7), 0);
        end
        add(0, 1, 2'd0, 2'd0, 1, 0);
        add(0, 1, 2'd0, 2'd0, 1, 0);
        // simultaneous push/pop: push 1, push 2, push 3 + pop
        add(1, 0, 2'd1, 2'd0, 0, 0);
        add(1, 0, 2'd2, 2'd0, 0, 0);
        add(1, 1, 2'd3, 2'd2, 0, 0);
        add(0, 1, 2'd0, 2'd3, 0, 0);
        add(0, 1, 2'd0, 2'd1, 1, 0);
        // push + pop on empty acts as push; data_out holds
        add(1, 1, 2'd2, 2'd1, 0, 0);
        add(0, 0, 2'd0, 2'd1, 0, 0);
        add(0, 1, 2'd0, 2'd2, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            chk($sformatf("v%0d_dout", i),  {6'd0, data_out}, {6'd0, vecs[i].exp_dout});
            chk($sformatf("v%0d_empty", i), {7'd0, empty},    {7'd0, vecs[i].exp_empty});
            chk($sformatf("v%0d_full", i),  {7'd0, full},     {7'd0, vecs[i].exp_full});
        end

        // ---------------- full + simultaneous push/pop ----------------
        for (int i = 0; i < 8; i++) step(1, 0, 2'(3 - (i % 4)));
        chk("fullswap_pre_full", {7'd0, full}, 8'd1);
        step(1, 1, 2'd3);   // top was 0 -> data_out 0, top becomes 3
        chk("fullswap_dout", {6'd0, data_out}, 8'd0);
        chk("fullswap_full", {7'd0, full}, 8'd1);
        step(0, 1, 2'd0);
        chk("fullswap_newtop", {6'd0, data_out}, 8'd3);
        chk("fullswap_notfull", {7'd0, full}, 8'd0);
        for (int i = 0; i < 7; i++) step(0, 1, 2'd0);
        chk("fullswap_drained", {7'd0, empty}, 8'd1);

        // ---------------- async reset mid-cycle ----------------
        step(1, 0, 2'd1);
        step(1, 0, 2'd2);
        step(1, 0, 2'd3);
        step(1, 0, 2'd1);
        step(0, 1, 2'd0);   // data_out = 1, three entries remain
        step(0, 0, 2'd0);
        chk("pre_arst_dout",  {6'd0, data_out}, 8'd1);
        chk("pre_arst_empty", {7'd0, empty}, 8'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_empty", {7'd0, empty}, 8'd1);
        chk("arst_dout",  {6'd0, data_out}, 8'd0);
        chk("arst_full",  {7'd0, full}, 8'd0);

        // ---------------- reset overrides push ----------------
        @(negedge clk);
        push = 1'b1; pop = 1'b0; data_in = 2'd3;
        @(posedge clk);
        #1;
        chk("rst_hold_empty", {7'd0, empty}, 8'd1);
        @(negedge clk);
        rst = 1'b1;          // push still high: first edge after release acts
        @(posedge clk);
        #1;
        chk("resume_empty", {7'd0, empty}, 8'd0);
        step(0, 1, 2'd0);
        chk("resume_dout",  {6'd0, data_out}, 8'd3);
        chk("resume_empty2", {7'd0, empty}, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_stack_2bit
`default_nettype wire

// File: doc/stack_2bit.md
STACK_2BIT -- requirements
Module: stack_2bit

Interface
REQ-001 Parameter WIDTH, default 2, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of stack entries (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 push  input  1  write request; sampled on the rising edge of clk.
REQ-006 pop  input  1  read request; sampled on the rising edge of clk.
REQ-007 data_in  input  WIDTH  word to push.
REQ-008 data_out  output  WIDTH  registered word last popped.
REQ-009 empty  output  1  high when the entry count is 0.
REQ-010 full  output  1  high when the entry count equals DEPTH.

Function
REQ-011 The block SHALL be a LIFO of DEPTH entries with a count/pointer register of clog2(DEPTH)+1 bits.
REQ-012 Push with pop low and not full: data_in is written at index count, and count increments by 1 on the same edge.
REQ-013 Pop with push low and not empty: entry count-1 is loaded into data_out, and count decrements by 1 on the same edge.
REQ-014 Push when full (pop low): ignored; memory, count and data_out are unchanged, with no wrap-around.
REQ-015 Pop when empty (push low): ignored; count stays 0 and data_out holds its previous value.
REQ-016 Push and pop together, not empty: data_out loads the current top, the top entry is overwritten with data_in, and count is unchanged.
REQ-017 Push and pop together, empty: treated as a push only; data_out holds its value.
REQ-018 data_out SHALL change only on a successful pop (one-cycle latency from the sampled pop) or on reset.
REQ-019 empty and full SHALL be combinational decodes of count, valid in the same cycle the count changes.
REQ-020 Holding push or pop high for N cycles SHALL perform N operations, each subject to REQ-014/015; there is no edge detection.
REQ-021 No other outputs or handshakes exist; operations complete in one cycle.

Reset
REQ-022 When rst is low, count SHALL be 0, data_out 0, empty 1 and full 0, immediately and without waiting for clk.
REQ-023 Memory contents need not be cleared; unread entries are don't-care after reset.
REQ-024 Reset asserted mid-operation SHALL override any push or pop in that cycle.
REQ-025 Normal operation resumes on the first rising edge after rst deasserts.

Structure
REQ-026 Package stack_pkg SHALL hold the WIDTH and DEPTH defaults and the derived pointer width constant.
REQ-027 The storage array may be a sub-module stack_mem (synchronous write, asynchronous read); the control and count logic stay in stack_2bit.
REQ-028 All sequential logic SHALL use a single always block sensitive to posedge clk and negedge rst.

Verification
REQ-029 Reset: hold rst low, then pop once after release -> empty=1, full=0, data_out=0, and count remains 0.
REQ-030 Fill: push data_in 0,1,2,3,0,1,2,3 on consecutive cycles -> full=1 after the 8th push, and empty=0 after the 1st.
REQ-031 Overflow: with the stack full, push 2'b10 for two more cycles -> full stays 1, and subsequent pops return 3,2,1,0,3,2,1,0.
REQ-032 Drain/underflow: pop 10 times after the fill -> data_out follows 3,2,1,0,3,2,1,0 one cycle after each pop, then holds 0; empty=1 after the 8th pop.
REQ-033 Simultaneous push and pop: push 1, then 2, then push 3 with pop -> data_out=2, and a following pop returns 3, then 1.
REQ-034 Async reset: assert rst between clock edges with 3 entries stored -> empty=1 and data_out=0 before the next edge.
